// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and bubble insertion (empty stage drives zero ctrl/payload).
module pipe_stage_reg #(
   parameter int PAYLOAD_W = 69,
   parameter int CTRL_W    = 4,
   parameter bit SKID      = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [CTRL_W-1:0]    in_ctrl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [1:0]           count
);

   logic                 main_valid;
   logic [PAYLOAD_W-1:0] main_payload;
   logic [CTRL_W-1:0]    main_ctrl;
   logic                 skid_valid;
   logic                 accept;
   logic                 retire;

   assign accept = in_valid && in_ready;
   assign retire = main_valid && out_ready;

   generate
      if (SKID) begin : g_skid
         logic                 skid_v;
         logic [PAYLOAD_W-1:0] skid_payload;
         logic [CTRL_W-1:0]    skid_ctrl;

         assign skid_valid = skid_v;
         // Only registered state gates acceptance; out_ready never reaches in_ready.
         assign in_ready = !skid_v && !reset && !flush;

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               main_valid   <= 1'b0;
               main_payload <= '0;
               main_ctrl    <= '0;
               skid_v       <= 1'b0;
               skid_payload <= '0;
               skid_ctrl    <= '0;
            end else if (!main_valid || retire) begin
               if (skid_v) begin
                  main_valid   <= 1'b1;
                  main_payload <= skid_payload;
                  main_ctrl    <= skid_ctrl;
                  skid_v       <= 1'b0;
                  skid_payload <= '0;
                  skid_ctrl    <= '0;
               end else if (accept) begin
                  main_valid   <= 1'b1;
                  main_payload <= in_payload;
                  main_ctrl    <= in_ctrl;
               end else begin
                  main_valid   <= 1'b0;
                  main_payload <= '0;
                  main_ctrl    <= '0;
               end
            end else if (accept) begin
               skid_v       <= 1'b1;
               skid_payload <= in_payload;
               skid_ctrl    <= in_ctrl;
            end
         end
      end else begin : g_single
         assign skid_valid = 1'b0;
         assign in_ready   = (!main_valid || out_ready) && !reset && !flush;

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               main_valid   <= 1'b0;
               main_payload <= '0;
               main_ctrl    <= '0;
            end else if (accept) begin
               main_valid   <= 1'b1;
               main_payload <= in_payload;
               main_ctrl    <= in_ctrl;
            end else if (retire) begin
               main_valid   <= 1'b0;
               main_payload <= '0;
               main_ctrl    <= '0;
            end
         end
      end
   endgenerate

   assign out_valid   = main_valid;
   assign out_payload = main_payload;
   assign out_ctrl    = main_ctrl;
   assign count       = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance and one single-register
// instance, checked with immediate assertions against hand-computed values.
module tb_pipe_stage_reg;

   localparam int PW = 69;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;

   logic          fl, iv, ir, ov, ordy;
   logic [PW-1:0] ip, op;
   logic [CW-1:0] ic, oc;
   logic [1:0]    cnt;

   logic          fl0, iv0, ir0, ov0, ordy0;
   logic [PW-1:0] ip0, op0;
   logic [CW-1:0] ic0, oc0;
   logic [1:0]    cnt0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1'b1)) u_dut (
      .clk(clk), .reset(rst), .flush(fl),
      .in_valid(iv), .in_ready(ir), .in_payload(ip), .in_ctrl(ic),
      .out_valid(ov), .out_ready(ordy), .out_payload(op), .out_ctrl(oc),
      .count(cnt)
   );

   pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1'b0)) u_dut0 (
      .clk(clk), .reset(rst), .flush(fl0),
      .in_valid(iv0), .in_ready(ir0), .in_payload(ip0), .in_ctrl(ic0),
      .out_valid(ov0), .out_ready(ordy0), .out_payload(op0), .out_ctrl(oc0),
      .count(cnt0)
   );

   task automatic chk(input string tag, input logic [79:0] obs,
                      input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [PW-1:0] A = 69'h0AAAA;
   localparam logic [PW-1:0] B = 69'h0BBBB;
   localparam logic [PW-1:0] C = 69'h0CCCC;
   localparam logic [PW-1:0] D = 69'h0DDDD;

   initial begin
      rst = 1'b1; fl = 1'b0; iv = 1'b1; ordy = 1'b1;
      ip = 69'h1_2345_6789; ic = 4'hF;
      fl0 = 1'b0; iv0 = 1'b0; ordy0 = 1'b1; ip0 = '0; ic0 = '0;

      // reset held two cycles with valid input present
      tick();
      tick();
      chk("rst_out_valid", 80'(ov), 80'd0);
      chk("rst_out_ctrl", 80'(oc), 80'd0);
      chk("rst_out_payload", 80'(op), 80'd0);
      chk("rst_count", 80'(cnt), 80'd0);
      chk("rst_in_ready_low", 80'(ir), 80'd0);
      chk("rst_count0", 80'(cnt0), 80'd0);
      rst = 1'b0; iv = 1'b0;
      #1;
      chk("post_rst_in_ready", 80'(ir), 80'd1);

      // streaming 1..8 with out_ready high
      for (int i = 1; i <= 8; i++) begin
         iv = 1'b1; ip = PW'(i); ic = 4'hF;
         tick();
         chk($sformatf("stream_valid_%0d", i), 80'(ov), 80'd1);
         chk($sformatf("stream_payload_%0d", i), 80'(op), 80'(i));
         chk($sformatf("stream_count_%0d", i), 80'(cnt), 80'd1);
      end
      chk("stream_ctrl", 80'(oc), 80'hF);
      iv = 1'b0;
      tick();
      chk("drain_valid", 80'(ov), 80'd0);
      chk("drain_ctrl", 80'(oc), 80'd0);
      chk("drain_payload", 80'(op), 80'd0);
      chk("drain_count", 80'(cnt), 80'd0);

      // backpressure fills the skid entry
      ordy = 1'b0; iv = 1'b1; ip = A; ic = 4'h3;
      tick();
      ip = B; ic = 4'h5;
      tick();
      iv = 1'b0;
      #1;
      chk("bp_count", 80'(cnt), 80'd2);
      chk("bp_in_ready", 80'(ir), 80'd0);
      chk("bp_head", 80'(op), 80'(A));
      chk("bp_head_ctrl", 80'(oc), 80'h3);
      ordy = 1'b1;
      tick();
      chk("bp_second", 80'(op), 80'(B));
      chk("bp_second_ctrl", 80'(oc), 80'h5);
      chk("bp_count_1", 80'(cnt), 80'd1);
      chk("bp_in_ready_back", 80'(ir), 80'd1);
      tick();
      chk("bp_empty", 80'(ov), 80'd0);
      chk("bp_count_0", 80'(cnt), 80'd0);

      // flush with simultaneous input
      ordy = 1'b0; iv = 1'b1; ip = A; ic = 4'h3;
      tick();
      ip = B; ic = 4'h5;
      tick();
      chk("fl_pre_count", 80'(cnt), 80'd2);
      fl = 1'b1; ip = C; ic = 4'h7;
      #1;
      chk("fl_in_ready", 80'(ir), 80'd0);
      tick();
      chk("fl_count", 80'(cnt), 80'd0);
      chk("fl_valid", 80'(ov), 80'd0);
      chk("fl_ctrl", 80'(oc), 80'd0);
      chk("fl_payload", 80'(op), 80'd0);
      fl = 1'b0; iv = 1'b0; ordy = 1'b1;
      tick();
      chk("fl_c_dropped", 80'(ov), 80'd0);

      // reset mid-stream with two entries held
      ordy = 1'b0; iv = 1'b1; ip = A; ic = 4'h3;
      tick();
      ip = B; ic = 4'h5;
      tick();
      iv = 1'b0;
      chk("mr_pre_count", 80'(cnt), 80'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_count", 80'(cnt), 80'd0);
      chk("mr_valid", 80'(ov), 80'd0);
      chk("mr_payload", 80'(op), 80'd0);
      chk("mr_ctrl", 80'(oc), 80'd0);
      iv = 1'b1; ip = D; ic = 4'h9;
      #1;
      chk("mr_in_ready", 80'(ir), 80'd1);
      tick();
      iv = 1'b0;
      chk("mr_d_valid", 80'(ov), 80'd1);
      chk("mr_d_payload", 80'(op), 80'(D));
      chk("mr_d_ctrl", 80'(oc), 80'h9);

      // single-register mode: combinational in_ready from out_ready
      ordy0 = 1'b0; iv0 = 1'b1; ip0 = 69'h0E0E0; ic0 = 4'h2;
      tick();
      chk("s0_valid", 80'(ov0), 80'd1);
      chk("s0_in_ready_low", 80'(ir0), 80'd0);
      chk("s0_count", 80'(cnt0), 80'd1);
      ordy0 = 1'b1; ip0 = 69'h0F2F2; ic0 = 4'h6;
      #1;
      chk("s0_in_ready_high", 80'(ir0), 80'd1);
      tick();
      chk("s0_pass_count", 80'(cnt0), 80'd1);
      chk("s0_pass_payload", 80'(op0), 80'h0F2F2);
      chk("s0_pass_ctrl", 80'(oc0), 80'h6);
      for (int i = 20; i < 23; i++) begin
         ip0 = PW'(i);
         tick();
         chk($sformatf("s0_stream_%0d", i), 80'(op0), 80'(i));
         chk($sformatf("s0_stream_cnt_%0d", i), 80'(cnt0), 80'd1);
      end
      iv0 = 1'b0;
      tick();
      chk("s0_drain_valid", 80'(ov0), 80'd0);
      chk("s0_drain_ctrl", 80'(oc0), 80'd0);
      chk("s0_drain_count", 80'(cnt0), 80'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
